// File: rtl/bash_hash_params_pkg.sv
// Shared Bash hash parameters, state type and the Bash-F round-constant step.
package bash_hash_params_pkg;

  localparam int unsigned SLEN          = 64;
  localparam int unsigned SWORDS        = 24;
  localparam int unsigned BASH_F_ROUNDS = 24;
  localparam int unsigned CNT_W         = 6;

  localparam logic [SLEN-1:0] BASH_F_INIT  = 64'hB194BAC80A08F53B;
  localparam logic [SLEN-1:0] BASH_F_CONST = 64'hAED8E07F99E12BDC;

  typedef logic [SWORDS*SLEN-1:0] bash_state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bash_f_sched_state_e;

  // Galois-style right shift with conditional feedback
  function automatic logic [63:0] bash_f_next_const(input logic [63:0] c);
    return (c >> 1) ^ (c[0] ? BASH_F_CONST : 64'h0);
  endfunction

endpackage

// File: rtl/bash_f_const_gen.sv
// Bash-F round-constant LFSR: reloads BASH_F_INIT on init_i, advances on step_i.
module bash_f_const_gen
  import bash_hash_params_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            init_i,
  input  logic            step_i,
  output logic [SLEN-1:0] const_o
);

  logic [SLEN-1:0] const_q, const_d;

  always_comb begin
    const_d = const_q;
    if (init_i) begin
      const_d = BASH_F_INIT;
    end else if (step_i) begin
      const_d = bash_f_next_const(const_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      const_q <= BASH_F_INIT;
    end else begin
      const_q <= const_d;
    end
  end

  assign const_o = const_q;

endmodule

// File: rtl/bash_f_sched.sv
// Bash-F round scheduler: owns the permutation state and sequences one round per cycle
// through an external combinational round core.
module bash_f_sched
  import bash_hash_params_pkg::*;
#(
  parameter int unsigned ROUNDS = BASH_F_ROUNDS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [SWORDS*SLEN-1:0] state_i,
  output logic [SWORDS*SLEN-1:0] state_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [SWORDS*SLEN-1:0] rnd_state_o,
  output logic [SLEN-1:0]        rnd_const_o,
  input  logic [SWORDS*SLEN-1:0] rnd_state_i
);

  localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(ROUNDS - 1);

  bash_f_sched_state_e fsm_q, fsm_d;
  bash_state_t         state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                const_init_c, const_step_c;
  logic [SLEN-1:0]     const_q;

  // Abort outranks both a new start and round completion
  always_comb begin
    fsm_d        = fsm_q;
    state_d      = state_q;
    cnt_d        = cnt_q;
    const_init_c = 1'b0;
    const_step_c = 1'b0;
    if (abort_i) begin
      fsm_d        = IDLE;
      cnt_d        = '0;
      const_init_c = 1'b1;
    end else begin
      unique case (fsm_q)
        IDLE, DONE: begin
          fsm_d = IDLE;
          if (start_i) begin
            fsm_d        = RUN;
            state_d      = state_i;
            cnt_d        = '0;
            const_init_c = 1'b1;
          end
        end
        RUN: begin
          state_d      = rnd_state_i;
          cnt_d        = cnt_q + CNT_W'(1);
          const_step_c = 1'b1;
          if (cnt_q == LAST_RND) begin
            fsm_d = DONE;
          end
        end
        default: fsm_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      cnt_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  bash_f_const_gen u_const_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .init_i  (const_init_c),
    .step_i  (const_step_c),
    .const_o (const_q)
  );

  assign busy_o      = (fsm_q == RUN);
  assign done_o      = (fsm_q == DONE);
  assign state_o     = state_q;
  assign rnd_state_o = state_q;
  assign rnd_const_o = const_q;

endmodule

// File: tb/tb_bash_f_sched.sv
// Self-checking bench for bash_f_sched with a word0-XOR round-core model.
module tb_bash_f_sched;

  localparam int unsigned SW   = 1536;
  localparam int unsigned NRND = 24;
  localparam logic [63:0] C_INIT = 64'hB194BAC80A08F53B;
  localparam logic [63:0] C_POLY = 64'hAED8E07F99E12BDC;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_i;
  logic          abort_i;
  logic [SW-1:0] state_i;
  logic [SW-1:0] state_o;
  logic          busy_o;
  logic          done_o;
  logic [SW-1:0] rnd_state_o;
  logic [63:0]   rnd_const_o;
  logic [SW-1:0] rnd_state_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rnd_state_i = {rnd_state_o[SW-1:64], rnd_state_o[63:0] ^ rnd_const_o};

  bash_f_sched dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .state_i     (state_i),
    .state_o     (state_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .rnd_state_o (rnd_state_o),
    .rnd_const_o (rnd_const_o),
    .rnd_state_i (rnd_state_i)
  );

  typedef struct {
    logic [SW-1:0] st_in;
    logic [SW-1:0] exp_out;
  } vec_t;

  vec_t vecs[6];

  // Reference: C_k obtained by stepping the LFSR definition k-1 times from C_INIT
  function automatic logic [63:0] ref_const(input int k);
    logic [63:0] c;
    c = C_INIT;
    for (int i = 1; i < k; i++) c = c[0] ? ((c >> 1) ^ C_POLY) : (c >> 1);
    return c;
  endfunction

  function automatic logic [SW-1:0] ref_perm(input logic [SW-1:0] s);
    logic [SW-1:0] r;
    r = s;
    for (int k = 1; k <= int'(NRND); k++) r[63:0] = r[63:0] ^ ref_const(k);
    return r;
  endfunction

  function automatic logic [SW-1:0] rnd_state();
    logic [SW-1:0] s;
    for (int i = 0; i < 48; i++) s[i*32 +: 32] = $urandom;
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic chk_state(input string nm, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    int bad;
    bad = -1;
    checks++;
    for (int w = 23; w >= 0; w--) if (act[w*64 +: 64] !== exp[w*64 +: 64]) bad = w;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s word%0d act=%h exp=%h", nm, bad, act[bad*64 +: 64], exp[bad*64 +: 64]);
    end
  endtask

  // One full permutation; optionally pulses start_i again in RUN cycle extra_cyc
  task automatic run_and_check(input string nm, input logic [SW-1:0] s_in, input int extra_cyc);
    logic [SW-1:0] exp;
    int cyc;
    exp = ref_perm(s_in);
    start_i = 1'b1;
    state_i = s_in;
    step();
    start_i = 1'b0;
    state_i = rnd_state();
    cyc = 1;
    while (done_o !== 1'b1 && cyc < 60) begin
      if (cyc <= int'(NRND)) begin
        chk64({nm, " rnd_const"}, rnd_const_o, ref_const(cyc));
        chk64({nm, " busy_run"}, 64'(busy_o), 64'd1);
      end
      if (cyc == 1) chk64({nm, " C1"}, rnd_const_o, 64'hB194BAC80A08F53B);
      if (cyc == 2) chk64({nm, " C2"}, rnd_const_o, 64'hF612BD1B9CE55141);
      if (cyc == extra_cyc) begin
        start_i = 1'b1;
        state_i = rnd_state();
      end
      step();
      start_i = 1'b0;
      cyc++;
    end
    chk64({nm, " done_cycle"}, 64'(cyc), 64'd25);
    chk_state({nm, " result"}, state_o, exp);
    chk64({nm, " busy_in_done"}, 64'(busy_o), 64'd0);
    step();
    chk64({nm, " done_pulse_len"}, 64'(done_o), 64'd0);
    chk64({nm, " busy_idle"}, 64'(busy_o), 64'd0);
    chk_state({nm, " held"}, state_o, exp);
  endtask

  initial begin
    logic [SW-1:0] s1, s2;
    int cyc, pulses;

    rst_n   = 1'b0;
    start_i = 1'b0;
    abort_i = 1'b0;
    state_i = '0;
    step();
    step();
    chk_state("rst state_o", state_o, '0);
    chk64("rst busy", 64'(busy_o), 64'd0);
    chk64("rst done", 64'(done_o), 64'd0);
    chk64("rst const", rnd_const_o, C_INIT);
    rst_n = 1'b1;
    step();

    vecs[0].st_in = '0;
    vecs[1].st_in = '1;
    for (int w = 0; w < 24; w++) vecs[2].st_in[w*64 +: 64] = {32'hA5A5_0000 + 32'(w), 32'(w) * 32'h0101_0101};
    for (int i = 3; i < 6; i++) vecs[i].st_in = rnd_state();
    for (int i = 0; i < 6; i++) vecs[i].exp_out = ref_perm(vecs[i].st_in);

    // Zero input: word0 ends as XOR of C1..C24, other words stay zero
    for (int i = 0; i < 6; i++) begin
      logic [SW-1:0] s;
      s = vecs[i].st_in;
      run_and_check($sformatf("vec%0d", i), s, -1);
      chk_state($sformatf("vec%0d table_exp", i), state_o, vecs[i].exp_out);
    end

    run_and_check("ign_start", rnd_state(), 5);

    // Abort in RUN cycle 10
    s1 = rnd_state();
    start_i = 1'b1;
    state_i = s1;
    step();
    start_i = 1'b0;
    for (int c = 1; c < 10; c++) step();
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    chk64("abort busy", 64'(busy_o), 64'd0);
    chk64("abort done", 64'(done_o), 64'd0);
    chk64("abort const_reinit", rnd_const_o, C_INIT);
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      if (done_o === 1'b1 || busy_o === 1'b1) pulses++;
      step();
    end
    chk64("abort no_done", 64'(pulses), 64'd0);
    run_and_check("after_abort", s1, -1);

    // Back-to-back: start held in DONE
    s1 = rnd_state();
    s2 = rnd_state();
    start_i = 1'b1;
    state_i = s1;
    step();
    start_i = 1'b0;
    cyc = 1;
    while (done_o !== 1'b1 && cyc < 60) begin
      step();
      cyc++;
    end
    chk64("b2b first_done", 64'(cyc), 64'd25);
    chk_state("b2b first_result", state_o, ref_perm(s1));
    start_i = 1'b1;
    state_i = s2;
    step();
    start_i = 1'b0;
    state_i = rnd_state();
    chk64("b2b busy_next", 64'(busy_o), 64'd1);
    chk64("b2b done_low", 64'(done_o), 64'd0);
    cyc = 1;
    while (done_o !== 1'b1 && cyc < 60) begin
      step();
      cyc++;
    end
    chk64("b2b second_done_gap", 64'(cyc), 64'd25);
    chk_state("b2b second_result", state_o, ref_perm(s2));
    step();

    // start and abort together in IDLE
    start_i = 1'b1;
    abort_i = 1'b1;
    state_i = rnd_state();
    step();
    start_i = 1'b0;
    abort_i = 1'b0;
    chk_state("start_abort state", state_o, ref_perm(s2));
    chk64("start_abort busy", 64'(busy_o), 64'd0);
    step();
    chk64("start_abort busy2", 64'(busy_o), 64'd0);
    chk64("start_abort done", 64'(done_o), 64'd0);

    // Async reset at round 12
    start_i = 1'b1;
    state_i = rnd_state();
    step();
    start_i = 1'b0;
    for (int c = 1; c < 12; c++) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk_state("areset state_o", state_o, '0);
    chk64("areset busy", 64'(busy_o), 64'd0);
    chk64("areset done", 64'(done_o), 64'd0);
    chk64("areset const", rnd_const_o, C_INIT);
    step();
    step();
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      if (done_o === 1'b1 || busy_o === 1'b1) pulses++;
      step();
    end
    chk64("areset no_done", 64'(pulses), 64'd0);
    chk_state("areset state_kept0", state_o, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
